// File: rtl/swervolf_gpio_pkg.sv
// swervolf_gpio_pkg: register offsets, bus width and byte-select helper for the GPIO input block
package swervolf_gpio_pkg;

    localparam int DW = 32;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_RISE   = 2'd1;
    localparam logic [1:0] REG_FALL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    function automatic logic [DW-1:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/swervolf_gpio_debounce.sv
// swervolf_gpio_debounce: one pin's 2-FF synchronizer plus tick-driven debounce (SWERVOLF_GPIO_DEBOUNCE_EN)
module swervolf_gpio_debounce
`ifdef SWERVOLF_GPIO_DEBOUNCE_EN
#(
    parameter int DB_COUNT = 10
)
`endif
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
`ifdef SWERVOLF_GPIO_DEBOUNCE_EN
    input  logic i_tick,
`endif
    output logic o_deb
);

    logic [1:0] sync_q;

    // two-flop synchronizer for the asynchronous board pin
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) sync_q <= '0;
        else sync_q <= {sync_q[0], i_pin};

`ifdef SWERVOLF_GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DB_COUNT + 1);

    logic [CW-1:0] cnt_q;
    logic          deb_q;

    // count ticks of disagreement; any agreement restarts the count, so short glitches never land
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else if (sync_q[1] == deb_q) begin
            cnt_q <= '0;
        end else if (i_tick) begin
            if (cnt_q == CW'(DB_COUNT - 1)) begin
                deb_q <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

    assign o_deb = deb_q;
`else
    assign o_deb = sync_q[1];
`endif

endmodule

// File: rtl/swervolf_gpio_in.sv
// swervolf_gpio_in: input GPIO with edge-triggered sticky status, level IRQ and Wishbone slave; debounce via SWERVOLF_GPIO_DEBOUNCE_EN
module swervolf_gpio_in
    import swervolf_gpio_pkg::*;
#(
    parameter int N        = 8,
    parameter int TICK_DIV = 25000,
    parameter int DB_COUNT = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_gpio,
    input  logic [1:0]    i_wb_adr,
    input  logic [DW-1:0] i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    output logic [DW-1:0] o_wb_rdt,
    output logic          o_wb_ack,
    output logic          o_irq
);

    if (N < 1 || N > 32 || TICK_DIV < 1 || DB_COUNT < 1 || DB_COUNT > 255) begin : g_bad_cfg
        $error("swervolf_gpio_in: parameter out of range");
    end

    logic [N-1:0]  deb, deb_q, rise_en_q, rise_en_d, fall_en_q, fall_en_d, status_q, status_d, clr;
    logic [DW-1:0] wmask, rdata, rdt_q;
    logic          ack_q, req, wr;

`ifdef SWERVOLF_GPIO_DEBOUNCE_EN
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre_q;
    logic          tick;

    assign tick = pre_q == PW'(TICK_DIV - 1);

    // free-running prescaler: one debounce sample tick every TICK_DIV clocks
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) pre_q <= '0;
        else pre_q <= tick ? '0 : pre_q + 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_pin
        swervolf_gpio_debounce #(.DB_COUNT(DB_COUNT)) u_deb (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_pin  (i_gpio[i]),
            .i_tick (tick),
            .o_deb  (deb[i])
        );
    end
`else
    for (genvar i = 0; i < N; i++) begin : g_pin
        swervolf_gpio_debounce u_deb (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_pin  (i_gpio[i]),
            .o_deb  (deb[i])
        );
    end
`endif

    assign req   = i_wb_cyc & i_wb_stb & ~ack_q;
    assign wr    = req & i_wb_we;
    assign wmask = byte_mask(i_wb_sel);

    // register writes, W1C with set-wins priority, and read mux
    always_comb begin
        rise_en_d = (wr && i_wb_adr == REG_RISE) ? N'((DW'(rise_en_q) & ~wmask) | (i_wb_dat & wmask)) : rise_en_q;
        fall_en_d = (wr && i_wb_adr == REG_FALL) ? N'((DW'(fall_en_q) & ~wmask) | (i_wb_dat & wmask)) : fall_en_q;
        clr       = (wr && i_wb_adr == REG_STATUS) ? N'(i_wb_dat & wmask) : '0;
        status_d  = (status_q & ~clr) | (deb & ~deb_q & rise_en_q) | (~deb & deb_q & fall_en_q);
        rdata     = i_wb_adr == REG_DATA ? DW'(deb) :
                    i_wb_adr == REG_RISE ? DW'(rise_en_q) :
                    i_wb_adr == REG_FALL ? DW'(fall_en_q) : DW'(status_q);
    end

    // state registers; read data is captured alongside the single-cycle ack
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            deb_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            ack_q     <= 1'b0;
            rdt_q     <= '0;
        end else begin
            deb_q     <= deb;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            ack_q     <= req;
            rdt_q     <= req ? rdata : '0;
        end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_irq    = |status_q;

endmodule

// File: tb/tb_swervolf_gpio_in.sv
// tb_swervolf_gpio_in: directed self-checking bench for swervolf_gpio_in (N=4, TICK_DIV=4, DB_COUNT=3)
module tb_swervolf_gpio_in;
    import swervolf_gpio_pkg::*;

`ifdef SWERVOLF_GPIO_DEBOUNCE_EN
    localparam int FALL_LAT = 12;
`else
    localparam int FALL_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  gpio;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [31:0] rdt;
    logic        ack, irq;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n;
    int          acks;
    logic [31:0] d;

    swervolf_gpio_in #(.N(4), .TICK_DIV(4), .DB_COUNT(3)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_gpio   (gpio),
        .i_wb_adr (adr),
        .i_wb_dat (dat),
        .i_wb_sel (sel),
        .i_wb_we  (we),
        .i_wb_cyc (cyc),
        .i_wb_stb (stb),
        .o_wb_rdt (rdt),
        .o_wb_ack (ack),
        .o_irq    (irq)
    );

    always #5 clk = ~clk;

    // edge counter since reset release, matching the prescaler phase
    always @(posedge clk or posedge rst)
        if (rst) n <= 0;
        else n <= n + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] wd, input logic [3:0] s, output logic [31:0] rd);
        logic ok = 1'b0;
        rd = 'x;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = wd; sel = s;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ack) begin
                ok = 1'b1;
                rd = rdt;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("wb_ack", {31'd0, ok}, 32'd1);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] s);
        logic [31:0] unused_rd;
        wb_xfer(1'b1, a, wd, s, unused_rd);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] rd);
        wb_xfer(1'b0, a, 32'd0, 4'hF, rd);
    endtask

    initial begin
        rst = 1'b1; gpio = 4'hF; adr = 2'd0; dat = 32'd0; sel = 4'h0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdt", rdt, 32'd0);
        rst = 1'b0;
        wb_read(REG_DATA, d);
        check("data_after_rst", d, 32'h0);
        repeat (20) @(posedge clk);
        #1;
        wb_read(REG_DATA, d);
        check("data_settled_F", d, 32'hF);
        wb_read(REG_STATUS, d);
        check("status_after_rst", d, 32'h0);
        check("irq_after_rst", {31'd0, irq}, 32'd0);

        gpio = 4'h0;
        repeat (20) @(posedge clk);
        #1;
        wb_read(REG_DATA, d);
        check("data_settled_0", d, 32'h0);
        wb_read(REG_STATUS, d);
        check("status_no_fall_en", d, 32'h0);

        wb_write(REG_RISE, 32'h1, 4'hF);
`ifdef SWERVOLF_GPIO_DEBOUNCE_EN
        gpio[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        gpio[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        wb_read(REG_DATA, d);
        check("glitch_data", d, 32'h0);
        wb_read(REG_STATUS, d);
        check("glitch_status", d, 32'h0);
        check("glitch_irq", {31'd0, irq}, 32'd0);
`endif

        gpio[0] = 1'b1;
        for (int k = 0; k < 17; k++) begin
            if (irq) break;
            @(posedge clk); #1;
        end
        check("rise_irq", {31'd0, irq}, 32'd1);
        wb_read(REG_STATUS, d);
        check("rise_status", d, 32'h1);
        wb_read(REG_DATA, d);
        check("rise_data", d, 32'h1);
        wb_write(REG_STATUS, 32'h1, 4'hF);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        wb_read(REG_STATUS, d);
        check("w1c_status", d, 32'h0);

        wb_write(REG_FALL, 32'h1, 4'hF);
        for (int k = 0; k < 4 && n % 4 != 0; k++) begin
            @(posedge clk); #1;
        end
        gpio[0] = 1'b0;
        repeat (FALL_LAT) @(posedge clk);
        #1;
        wb_write(REG_STATUS, 32'h1, 4'hF);
        check("collision_irq", {31'd0, irq}, 32'd1);
        wb_read(REG_STATUS, d);
        check("collision_status", d, 32'h1);
        wb_write(REG_STATUS, 32'hF, 4'hF);
        check("collision_clear_irq", {31'd0, irq}, 32'd0);

        wb_write(REG_RISE, 32'hFFFF_FFF5, 4'hF);
        wb_read(REG_RISE, d);
        check("rise_en_upper_ignored", d, 32'h5);
        wb_write(REG_RISE, 32'h0, 4'h0);
        wb_read(REG_RISE, d);
        check("rise_en_sel0", d, 32'h5);
        wb_write(REG_DATA, 32'hF, 4'hF);
        wb_read(REG_DATA, d);
        check("data_write_ignored", d, 32'h0);

        @(posedge clk); #1;
        adr = REG_RISE; we = 1'b0; cyc = 1'b1; stb = 1'b1; acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack) begin
                acks++;
                check("burst_rdt", rdt, 32'h5);
            end
        end
        cyc = 1'b0; stb = 1'b0;
        check("burst_acks", acks, 32'd3);
        @(posedge clk); #1;
        check("idle_rdt", rdt, 32'h0);

`ifndef SWERVOLF_GPIO_DEBOUNCE_EN
        wb_write(REG_RISE, 32'h0, 4'hF);
        wb_write(REG_FALL, 32'h4, 4'hF);
        wb_write(REG_STATUS, 32'hF, 4'hF);
        gpio[2] = 1'b1;
        @(posedge clk); #1;
        wb_read(REG_DATA, d);
        check("data_lag_one_edge", d, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        wb_read(REG_DATA, d);
        check("data_follow", d, 32'h4);
        gpio[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("fall_irq_early", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("fall_irq_set", {31'd0, irq}, 32'd1);
        wb_read(REG_STATUS, d);
        check("fall_status", d, 32'h4);
        wb_read(REG_DATA, d);
        check("fall_data", d, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
